digdug_inpcond: RTL and testbench



---
 rtl/digdug_inpcond.sv | 258 +++++++++++++++++++++++++
 tb/tb_digdug_inpcond.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digdug_inpcond.sv
// digdug_inpcond - input conditioner for the DigDug custom I/O emulation.
//
// Takes the raw active-low cabinet inputs, inverts them, runs every bit
// through a 2-flop synchroniser and a per-bit debouncer. Each coin becomes a
// frame-aligned pulse of COIN_FRAMES vertical blanks. Each joystick is limited
// to 4-way behaviour. The results are registered onto the active-high
// INP0/INP1 buses that feed the custom I/O block.
//
// Parameters:
//   DEB_CYCLES  - CL cycles an input must disagree with its debounced value
//                 before the new value is accepted (1..65535)
//   COIN_FRAMES - VBLK rising edges a coin pulse stays high (1..15)
//
// Ports:
//   CL           in   system clock
//   RESET_N      in   asynchronous active-low reset
//   VBLK         in   vertical blank, synchronous to CL
//   AUTOFIRE     in   autofire enable (only with INPCOND_AUTOFIRE_EN)
//   RAW_SERVICE  in   service switch, active-low
//   RAW_COIN     in   [1]=coin2 [0]=coin1, active-low
//   RAW_START    in   [1]=P2 [0]=P1, active-low
//   RAW_PUMP     in   [1]=P2 [0]=P1, active-low
//   RAW_STK1     in   P1 {left,down,right,up}, active-low
//   RAW_STK2     in   P2 {left,down,right,up}, active-low
//   INP0         out  {service,0,coin2,coin1,start2,start1,pump2,pump1}
//   INP1         out  {stk2[3:0],stk1[3:0]}
//
// Build option: define INPCOND_AUTOFIRE_EN to add the AUTOFIRE input and the
// per-player pump autofire. Without it the pumps pass straight through.
//
// Coin FSM:
//   state      | meaning
//   ST_IDLE    | waiting for a debounced coin, output 0
//   ST_PULSE   | coin pulse high, counting VBLK rising edges
//   ST_HOLDOFF | pulse done, waiting for the coin to be released at a VBLK edge

module digdug_inpcond #(
    parameter int unsigned DEB_CYCLES  = 4096,
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic       CL,
    input  logic       RESET_N,
    input  logic       VBLK,
`ifdef INPCOND_AUTOFIRE_EN
    input  logic       AUTOFIRE,
`endif
    input  logic       RAW_SERVICE,
    input  logic [1:0] RAW_COIN,
    input  logic [1:0] RAW_START,
    input  logic [1:0] RAW_PUMP,
    input  logic [3:0] RAW_STK1,
    input  logic [3:0] RAW_STK2,
    output logic [7:0] INP0,
    output logic [7:0] INP1
);

    localparam int NB = 15;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_TC  = CW'(DEB_CYCLES);
    localparam logic [3:0]    COIN_TC = 4'(COIN_FRAMES);

    // Bit map of the conditioned vector:
    // [14] service, [13:12] coin, [11:10] start, [9:8] pump, [7:4] stk2, [3:0] stk1
    localparam int B_STK2 = 4;
    localparam int B_PUMP = 8;
    localparam int B_COIN = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } coin_st_t;

    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] deb_q, deb_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];
    logic          vblk_q, vblk_d;
    logic          vrise;
    coin_st_t      coin_st_q [2];
    coin_st_t      coin_st_d [2];
    logic [3:0]    frame_q [2];
    logic [3:0]    frame_d [2];
    logic [1:0]    coin_o;
    logic [1:0]    pump_o;
    logic [3:0]    last1_q, last1_d;
    logic [3:0]    last2_q, last2_d;
    logic [7:0]    inp0_q, inp0_d;
    logic [7:0]    inp1_q, inp1_d;

    // 4-way arbitration. The chosen direction is also the new "last" value.
    function automatic logic [3:0] pick_dir(input logic [3:0] set, input logic [3:0] last);
        logic [3:0] lowest;
        logic       multi;
        lowest = set & (~set + 4'd1);
        multi  = (set & (set - 4'd1)) != 4'd0;
        if (!multi) begin
            pick_dir = set;
        end else if ((set & last) != 4'd0) begin
            pick_dir = last;
        end else begin
            pick_dir = lowest;
        end
    endfunction

    always_comb begin
        sync1_d = ~{RAW_SERVICE, RAW_COIN, RAW_START, RAW_PUMP, RAW_STK2, RAW_STK1};
        sync2_d = sync1_q;
        vblk_d  = VBLK;
        vrise   = VBLK & ~vblk_q;
    end

    // Debounce: count consecutive cycles of disagreement, accept on terminal count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] + CW'(1) == DEB_TC) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Coin FSMs. HOLDOFF only returns to IDLE with the coin released, so a
    // coin seen high in IDLE is always a fresh press.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            coin_st_d[i] = coin_st_q[i];
            frame_d[i]   = frame_q[i];
            case (coin_st_q[i])
                ST_IDLE: begin
                    if (deb_q[B_COIN+i]) begin
                        coin_st_d[i] = ST_PULSE;
                        frame_d[i]   = 4'd0;
                    end
                end
                ST_PULSE: begin
                    if (vrise) begin
                        if (frame_q[i] + 4'd1 == COIN_TC) begin
                            coin_st_d[i] = ST_HOLDOFF;
                            frame_d[i]   = 4'd0;
                        end else begin
                            frame_d[i] = frame_q[i] + 4'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (vrise && !deb_q[B_COIN+i]) begin
                        coin_st_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    coin_st_d[i] = ST_IDLE;
                    frame_d[i]   = 4'd0;
                end
            endcase
            // Driven from the next state so the pulse edges land on the
            // same CL edge as the state change.
            coin_o[i] = (coin_st_d[i] == ST_PULSE);
        end
    end

`ifdef INPCOND_AUTOFIRE_EN
    logic [1:0] pump_prev_q, pump_prev_d;
    logic [1:0] af_tog_q, af_tog_d;
    logic [1:0] af_cnt_q [2];
    logic [1:0] af_cnt_d [2];

    always_comb begin
        pump_prev_d = deb_q[B_PUMP+1:B_PUMP];
        af_tog_d    = af_tog_q;
        pump_o      = 2'b00;
        for (int i = 0; i < 2; i++) begin
            af_cnt_d[i] = af_cnt_q[i];
            if (deb_q[B_PUMP+i] && !pump_prev_q[i]) begin
                af_tog_d[i] = 1'b1;
                af_cnt_d[i] = 2'd0;
            end else if (deb_q[B_PUMP+i] && vrise) begin
                af_cnt_d[i] = af_cnt_q[i] + 2'd1;
                if (af_cnt_q[i] == 2'd3) begin
                    af_tog_d[i] = ~af_tog_q[i];
                end
            end
            pump_o[i] = AUTOFIRE ? (deb_q[B_PUMP+i] & af_tog_d[i]) : deb_q[B_PUMP+i];
        end
    end

    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            pump_prev_q <= 2'b00;
            af_tog_q    <= 2'b00;
            af_cnt_q[0] <= 2'd0;
            af_cnt_q[1] <= 2'd0;
        end else begin
            pump_prev_q <= pump_prev_d;
            af_tog_q    <= af_tog_d;
            af_cnt_q[0] <= af_cnt_d[0];
            af_cnt_q[1] <= af_cnt_d[1];
        end
    end
`else
    always_comb begin
        pump_o = deb_q[B_PUMP+1:B_PUMP];
    end
`endif

    always_comb begin
        last1_d = pick_dir(deb_q[3:0], last1_q);
        last2_d = pick_dir(deb_q[B_STK2+3:B_STK2], last2_q);
        inp0_d  = {deb_q[14], 1'b0, coin_o, deb_q[11:10], pump_o};
        inp1_d  = {last2_d, last1_d};
    end

    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            vblk_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                coin_st_q[i] <= ST_IDLE;
                frame_q[i]   <= 4'd0;
            end
            last1_q <= 4'd0;
            last2_q <= 4'd0;
            inp0_q  <= 8'd0;
            inp1_q  <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            vblk_q <= vblk_d;
            for (int i = 0; i < 2; i++) begin
                coin_st_q[i] <= coin_st_d[i];
                frame_q[i]   <= frame_d[i];
            end
            last1_q <= last1_d;
            last2_q <= last2_d;
            inp0_q  <= inp0_d;
            inp1_q  <= inp1_d;
        end
    end

    assign INP0 = inp0_q;
    assign INP1 = inp1_q;

endmodule

// File: tb/tb_digdug_inpcond.sv
`timescale 1ns/1ps
module tb_digdug_inpcond;

    localparam int DEB   = 4;
    localparam int CFR   = 3;
    localparam int FRAME = 16;

    logic       CL          = 1'b0;
    logic       RESET_N     = 1'b0;
    logic       VBLK        = 1'b0;
    logic       RAW_SERVICE = 1'b1;
    logic [1:0] RAW_COIN    = 2'b11;
    logic [1:0] RAW_START   = 2'b11;
    logic [1:0] RAW_PUMP    = 2'b11;
    logic [3:0] RAW_STK1    = 4'hF;
    logic [3:0] RAW_STK2    = 4'hF;
    logic [7:0] INP0;
    logic [7:0] INP1;
`ifdef INPCOND_AUTOFIRE_EN
    logic       AUTOFIRE    = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CL = ~CL;

    digdug_inpcond #(
        .DEB_CYCLES (DEB),
        .COIN_FRAMES(CFR)
    ) dut (
        .CL         (CL),
        .RESET_N    (RESET_N),
        .VBLK       (VBLK),
`ifdef INPCOND_AUTOFIRE_EN
        .AUTOFIRE   (AUTOFIRE),
`endif
        .RAW_SERVICE(RAW_SERVICE),
        .RAW_COIN   (RAW_COIN),
        .RAW_START  (RAW_START),
        .RAW_PUMP   (RAW_PUMP),
        .RAW_STK1   (RAW_STK1),
        .RAW_STK2   (RAW_STK2),
        .INP0       (INP0),
        .INP1       (INP1)
    );

    // ---------------- reference model ----------------
    // hist[j]: active-high raw vector sampled j edges ago
    // {service, coin[1:0], start[1:0], pump[1:0], stk2[3:0], stk1[3:0]}
    logic [14:0] hist [8];
    logic [14:0] m_deb;
    int          m_left  [2];   // VBLK rises left in the current coin pulse
    bit          m_armed [2];   // coin seen released at a VBLK rise since last pulse
    logic [3:0]  m_last  [2];
    logic        m_vprev;
    logic [7:0]  exp0, exp1;
`ifdef INPCOND_AUTOFIRE_EN
    int          m_af [2];      // VBLK rises since the pump press
    logic [1:0]  m_pprev;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [3:0] way4(input logic [3:0] s, input logic [3:0] last);
        if ((s & last) != 4'd0) return last;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) return 4'(1 << k);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 8; j++) hist[j] = '0;
        m_deb = '0;
        for (int i = 0; i < 2; i++) begin
            m_left[i]  = 0;
            m_armed[i] = 1'b1;
            m_last[i]  = 4'd0;
        end
        m_vprev = 1'b0;
        exp0 = 8'd0;
        exp1 = 8'd0;
`ifdef INPCOND_AUTOFIRE_EN
        m_af[0] = 0;
        m_af[1] = 0;
        m_pprev = 2'b00;
`endif
    endtask

    task automatic model_step();
        logic       vr;
        logic [1:0] cout;
        logic [1:0] pout;
        logic [3:0] s1, s2;
        logic       flip;
        vr = VBLK && !m_vprev;
        m_vprev = VBLK;
        for (int i = 0; i < 2; i++) begin
            if (m_left[i] > 0) begin
                if (vr) m_left[i]--;
            end else if (!m_armed[i]) begin
                if (vr && !m_deb[12+i]) m_armed[i] = 1'b1;
            end else if (m_deb[12+i]) begin
                m_left[i]  = CFR;
                m_armed[i] = 1'b0;
            end
            cout[i] = (m_left[i] > 0);
        end
        s1 = way4(m_deb[3:0], m_last[0]);
        s2 = way4(m_deb[7:4], m_last[1]);
        m_last[0] = s1;
        m_last[1] = s2;
        pout = m_deb[9:8];
`ifdef INPCOND_AUTOFIRE_EN
        for (int i = 0; i < 2; i++) begin
            if (m_deb[8+i] && !m_pprev[i]) m_af[i] = 0;
            else if (m_deb[8+i] && vr) m_af[i]++;
            m_pprev[i] = m_deb[8+i];
            if (AUTOFIRE) pout[i] = m_deb[8+i] && (((m_af[i] / 4) % 2) == 0);
        end
`endif
        exp0 = {m_deb[14], 1'b0, cout, m_deb[11:10], pout};
        exp1 = {s2, s1};
        for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = ~{RAW_SERVICE, RAW_COIN, RAW_START, RAW_PUMP, RAW_STK2, RAW_STK1};
        // A bit flips once DEB consecutive synchronised samples disagree with it.
        for (int b = 0; b < 15; b++) begin
            flip = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) begin
                if (hist[j][b] == m_deb[b]) flip = 1'b0;
            end
            if (flip) m_deb[b] = ~m_deb[b];
        end
    endtask

    task automatic tick();
        @(posedge CL);
        if (!RESET_N) model_reset();
        else model_step();
        @(negedge CL);
        check_val("model_inp0", INP0, exp0);
        check_val("model_inp1", INP1, exp1);
        cyc++;
        VBLK = (cyc % FRAME) < 2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int pulses;
        logic prev;
        logic [14:0] rawv;
        model_reset();

        // reset state
        ticks(3);
        check_val("rst_inp0", INP0, 8'h00);
        check_val("rst_inp1", INP1, 8'h00);
        RESET_N = 1'b1;
        ticks(4);

        // short glitch never reaches the output
        RAW_PUMP[0] = 1'b0;
        ticks(DEB - 1);
        RAW_PUMP[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("glitch_inp0", INP0, 8'h00);
        end

        // clean press: exactly DEB+3 edges of latency
        RAW_PUMP[0] = 1'b0;
        for (int n = 1; n <= DEB + 3; n++) begin
            tick();
            check_val("deb_latency", INP0[0], (n == DEB + 3) ? 1 : 0);
        end
        RAW_PUMP[0] = 1'b1;
        ticks(10);

        // 4-way stick
        RAW_STK1 = 4'b1110; ticks(8); check_val("stk_up",       INP1, 8'h01);
        RAW_STK1 = 4'b1100; ticks(8); check_val("stk_up_right", INP1, 8'h01);
        RAW_STK1 = 4'b1101; ticks(8); check_val("stk_right",    INP1, 8'h02);
        RAW_STK1 = 4'b1111; ticks(8); check_val("stk_none",     INP1, 8'h00);
        RAW_STK1 = 4'b0110; ticks(8); check_val("stk_up_left",  INP1, 8'h01);
        RAW_STK1 = 4'b1111; ticks(8);

        // coin held for 10 frames gives one pulse of COIN_FRAMES VBLK rises
        for (int rep = 0; rep < 2; rep++) begin
            RAW_COIN[0] = 1'b0;
            hi = 0; pulses = 0; prev = 1'b0;
            for (int k = 0; k < 10 * FRAME; k++) begin
                tick();
                if (INP0[4]) hi++;
                if (INP0[4] && !prev) pulses++;
                prev = INP0[4];
            end
            check_val("coin_pulses", pulses, 1);
            check_val("coin_len_ok", (hi > (CFR - 1) * FRAME && hi <= CFR * FRAME) ? 1 : 0, 1);
            check_val("coin_held_end", INP0, 8'h00);
            RAW_COIN[0] = 1'b1;
            ticks(2 * FRAME);
        end

        // both coins plus service together
        RAW_COIN = 2'b00;
        RAW_SERVICE = 1'b0;
        for (int k = 0; k < 20 && INP0 == 8'h00; k++) tick();
        check_val("simul_pulse", INP0, 8'hB0);
        ticks(4 * FRAME);
        check_val("simul_after", INP0, 8'h80);
        RAW_COIN = 2'b11;
        RAW_SERVICE = 1'b1;
        ticks(2 * FRAME);

        // reset in the middle of a coin pulse
        RAW_COIN[1] = 1'b0;
        for (int k = 0; k < 20 && !INP0[5]; k++) tick();
        check_val("pulse_before_rst", INP0[5], 1);
        ticks(2);
        RESET_N = 1'b0;
        #1;
        check_val("async_rst_inp0", INP0, 8'h00);
        check_val("async_rst_inp1", INP1, 8'h00);
        RAW_COIN = 2'b11;
        ticks(3);
        RESET_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_val("post_rst_inp0", INP0, 8'h00);
        end

`ifdef INPCOND_AUTOFIRE_EN
        AUTOFIRE = 1'b1;
        RAW_PUMP[1] = 1'b0;
        ticks(DEB + 3);
        hi = 0; prev = INP0[1];
        for (int k = 0; k < 10 * FRAME; k++) begin
            tick();
            if (INP0[1] != prev) hi++;
            prev = INP0[1];
        end
        check_val("af_toggles", (hi >= 2) ? 1 : 0, 1);
        AUTOFIRE = 1'b0;
        ticks(2);
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            check_val("af_off_pump", INP0[1], 1);
        end
        RAW_PUMP[1] = 1'b1;
        ticks(10);
`endif

        // randomized stimulus, checked against the model every cycle
        rawv = {RAW_SERVICE, RAW_COIN, RAW_START, RAW_PUMP, RAW_STK2, RAW_STK1};
        for (int k = 0; k < 3000; k++) begin
            int r;
            int b;
            r = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 14));
            if (r == 0) begin
                rawv[b] = ~rawv[b];
            end else if (r == 1) begin
                rawv[b] = ~rawv[b];
                {RAW_SERVICE, RAW_COIN, RAW_START, RAW_PUMP, RAW_STK2, RAW_STK1} = rawv;
                ticks(int'($urandom_range(1, DEB - 1)));
                rawv[b] = ~rawv[b];
            end
            {RAW_SERVICE, RAW_COIN, RAW_START, RAW_PUMP, RAW_STK2, RAW_STK1} = rawv;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
